bus_arbiter: RTL and testbench

- Shares the single memory bus master between the fetch unit (instruction reads) and the execute unit (loads/stores).
- Sits between both requesters and the bus interconnect.
- Serialises one transaction at a time: execute has priority, fetch has a starvation guard.
- Also handles flush-discarded fetches and per-transaction timeouts.

---
 rtl/bus_arbiter_if.sv | 38 +++
 rtl/bus_arbiter.sv | 108 ++++++++++
 tb/tb_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the fetch unit, the execute unit and the memory bus.
// The arbiter connects through the master modport; the environment uses slave.
interface bus_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        f_error;

  logic        e_req;
  logic        e_write;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_done;
  logic [31:0] e_rdata;
  logic        e_error;

  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_done;
  logic [31:0] m_rdata;

  modport master (
    input  f_req, f_addr, e_req, e_write, e_addr, e_wdata, e_wstrb, m_done, m_rdata,
    output f_done, f_rdata, f_error, e_done, e_rdata, e_error,
           m_req, m_write, m_addr, m_wdata, m_wstrb
  );

  modport slave (
    output f_req, f_addr, e_req, e_write, e_addr, e_wdata, e_wstrb, m_done, m_rdata,
    input  f_done, f_rdata, f_error, e_done, e_rdata, e_error,
           m_req, m_write, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/bus_arbiter.sv
// Serialises fetch and execute transactions onto one bus master port: execute
// wins ties, fetch gets a forced grant after STARVE_LIMIT contended losses.
module bus_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          flush,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_E} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
  localparam bit         TO_EN      = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [7:0]  to_cnt;
  logic        discard;

  logic        fetch_vld;
  logic        grant_e;
  logic        grant_f;
  logic        to_hit;
  logic        finish;

  always_comb begin
    fetch_vld = bus.f_req && !flush;
    grant_e   = bus.e_req && !(fetch_vld && (starve_cnt >= STARVE_MAX));
    grant_f   = fetch_vld && !grant_e;
    // to_cnt counts completed m_req cycles, so TO_LAST marks the final allowed one
    to_hit    = TO_EN && (to_cnt == TO_LAST);
    finish    = bus.m_req && (bus.m_done || to_hit);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      to_cnt      <= '0;
      discard     <= 1'b0;
      bus.m_req   <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
      bus.f_done  <= 1'b0;
      bus.f_error <= 1'b0;
      bus.f_rdata <= '0;
      bus.e_done  <= 1'b0;
      bus.e_error <= 1'b0;
      bus.e_rdata <= '0;
    end else begin
      bus.f_done  <= 1'b0;
      bus.f_error <= 1'b0;
      bus.e_done  <= 1'b0;
      bus.e_error <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (grant_e) begin
            state       <= BUSY_E;
            bus.m_req   <= 1'b1;
            bus.m_write <= bus.e_write;
            bus.m_addr  <= bus.e_addr;
            bus.m_wdata <= bus.e_wdata;
            bus.m_wstrb <= bus.e_write ? bus.e_wstrb : 4'b0000;
            if (fetch_vld) starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_f) begin
            state       <= BUSY_F;
            bus.m_req   <= 1'b1;
            bus.m_write <= 1'b0;
            bus.m_addr  <= bus.f_addr;
            bus.m_wdata <= '0;
            bus.m_wstrb <= 4'b0000;
            starve_cnt  <= '0;
          end
        end
        BUSY_F, BUSY_E: begin
          to_cnt <= to_cnt + 8'd1;
          // A flushed fetch still runs to completion on the bus; only its result is dropped
          if ((state == BUSY_F) && flush) discard <= 1'b1;
          if (finish) begin
            state     <= IDLE;
            bus.m_req <= 1'b0;
            discard   <= 1'b0;
            if (state == BUSY_F) begin
              if (!(discard || flush)) begin
                bus.f_done  <= 1'b1;
                bus.f_error <= !bus.m_done;
                bus.f_rdata <= bus.m_done ? bus.m_rdata : 32'h0;
              end
            end else begin
              bus.e_done  <= 1'b1;
              bus.e_error <= !bus.m_done;
              bus.e_rdata <= (bus.m_done && !bus.m_write) ? bus.m_rdata : 32'h0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: table of single transactions, directed multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int          STARVE_LIMIT   = 4;
  localparam int          TIMEOUT_CYCLES = 8;
  localparam logic [31:0] F_ADDR         = 32'h0000_F000;
  localparam logic [31:0] E_ADDR         = 32'h0000_E000;

  logic clock  = 1'b0;
  logic nreset = 1'b1;
  logic flush  = 1'b0;

  bus_arbiter_if bus ();

  bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock (clock),
    .nreset(nreset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int          sq_delay[$];
  logic [31:0] sq_data[$];

  typedef struct {
    bit          is_e;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bus slave: answers the k-th transaction after sq_delay[k] extra cycles.
  int          s_cnt;
  int          s_delay;
  logic [31:0] s_data;
  bit          s_active;

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s_active   = 1'b0;
      bus.m_done = 1'b0;
    end else begin
      #1;
      if (bus.m_req) begin
        if (!s_active) begin
          s_active = 1'b1;
          s_cnt    = 0;
          if (sq_delay.size() > 0) begin
            s_delay = sq_delay.pop_front();
            s_data  = sq_data.pop_front();
          end else begin
            s_delay = 1000;
            s_data  = 32'h0;
          end
        end else begin
          s_cnt++;
        end
      end else begin
        s_active = 1'b0;
      end
      bus.m_done  = bus.m_req && s_active && (s_cnt == s_delay);
      bus.m_rdata = bus.m_done ? s_data : $urandom;
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, " ctl"}, {bus.f_done, bus.f_error, bus.e_done, bus.e_error,
                       bus.m_req, bus.m_write, bus.m_wstrb}, '0);
    chk({nm, " m_addr/m_wdata"}, {bus.m_addr, bus.m_wdata}, '0);
    chk({nm, " rdata"}, {bus.f_rdata, bus.e_rdata}, '0);
  endtask

  task automatic run_single(input vec_t v, input string nm);
    int lat;
    bit got;
    sq_delay.push_back(v.delay);
    sq_data.push_back(v.rdata);
    if (v.is_e) begin
      bus.e_req = 1'b1; bus.e_write = v.wr; bus.e_addr = v.addr;
      bus.e_wdata = v.wdata; bus.e_wstrb = v.wstrb;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = v.addr;
    end
    tick();
    bus.f_req = 1'b0;
    bus.e_req = 1'b0;
    @(negedge clock);
    chk({nm, " grant"}, {bus.m_req, bus.m_write, bus.m_wstrb, bus.m_addr, bus.m_wdata},
        {1'b1, v.is_e && v.wr, (v.is_e && v.wr) ? v.wstrb : 4'h0, v.addr,
         v.is_e ? v.wdata : 32'h0});
    got = 1'b0;
    lat = 1;
    while (!got && lat < 40) begin
      if (bus.f_done || bus.e_done) got = 1'b1;
      else begin
        tick();
        @(negedge clock);
        lat++;
      end
    end
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " which done"}, {bus.f_done, bus.e_done}, {!v.is_e, v.is_e});
    chk({nm, " rdata"}, v.is_e ? bus.e_rdata : bus.f_rdata, v.exp_rdata);
    chk({nm, " error"}, v.is_e ? bus.e_error : bus.f_error, v.exp_err);
    tick();
  endtask

  // Hold both requests until n grants are seen; bit i of seq = 1 when grant i went to fetch.
  task automatic collect_grants(input int n, output logic [15:0] seq, output int got);
    bit prev;
    seq  = '0;
    got  = 0;
    prev = bus.m_req;
    bus.f_req = 1'b1; bus.f_addr = F_ADDR;
    bus.e_req = 1'b1; bus.e_write = 1'b1; bus.e_addr = E_ADDR;
    bus.e_wdata = 32'h5555_AAAA; bus.e_wstrb = 4'hF;
    for (int c = 0; c < 120 && got < n; c++) begin
      @(negedge clock);
      if (bus.m_req && !prev) begin
        seq[got] = (bus.m_addr == F_ADDR);
        got++;
      end
      prev = bus.m_req;
      tick();
    end
    bus.f_req = 1'b0;
    bus.e_req = 1'b0;
  endtask

  task automatic flush_case(input bit is_e, input int delay, input int fc,
                            input logic [7:0] exp_mr, input logic [7:0] exp_dn,
                            input string nm);
    logic [7:0] mr;
    logic [7:0] dn;
    sq_delay.push_back(delay);
    sq_data.push_back(32'h600D_0000 + delay);
    if (is_e) begin
      bus.e_req = 1'b1; bus.e_write = 1'b0; bus.e_addr = 32'h4000;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = 32'h300;
    end
    tick();
    bus.e_req = 1'b0;
    bus.f_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      flush = (c == fc);
      @(negedge clock);
      mr[c] = bus.m_req;
      dn[c] = is_e ? bus.e_done : bus.f_done;
      tick();
    end
    flush = 1'b0;
    chk({nm, " m_req trace"}, mr, exp_mr);
    chk({nm, " done trace"}, dn, exp_dn);
  endtask

  task automatic random_test(input int ncyc);
    int          md[$];
    logic [31:0] mrd[$];
    int          starve;
    int          bf, bt, done_t;
    bit          own_e, flush_seen, d_e, d_err, d_disc;
    logic [31:0] d_rdata;
    logic [68:0] m_exp;
    bit          exp_mreq, exp_fd, exp_ed;
    starve = 0; bf = 1; bt = 0; done_t = -1;
    own_e = 1'b0; flush_seen = 1'b0; d_e = 1'b0; d_err = 1'b0; d_disc = 1'b0;
    d_rdata = '0; m_exp = '0;
    sq_delay.delete();
    sq_data.delete();
    for (int k = 0; k < ncyc; k++) begin
      int          d;
      logic [31:0] r;
      d = $urandom_range(0, 11);
      r = $urandom;
      sq_delay.push_back(d); sq_data.push_back(r);
      md.push_back(d);       mrd.push_back(r);
    end
    for (int t = 0; t < ncyc; t++) begin
      bit          fr, er, fl, ew;
      logic [31:0] fa, ea, ewd;
      logic [3:0]  es;
      fr = ($urandom_range(0, 2) == 0);
      er = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 5) == 0);
      ew = $urandom_range(0, 1);
      fa = $urandom; ea = $urandom; ewd = $urandom; es = 4'($urandom);
      bus.f_req = fr; bus.f_addr = fa;
      bus.e_req = er; bus.e_write = ew; bus.e_addr = ea; bus.e_wdata = ewd; bus.e_wstrb = es;
      flush = fl;
      @(negedge clock);
      exp_mreq = (t >= bf) && (t <= bt);
      exp_fd   = (t == done_t) && !d_e && !d_disc;
      exp_ed   = (t == done_t) && d_e;
      chk("rnd ctl", {bus.m_req, bus.f_done, bus.f_error, bus.e_done, bus.e_error},
          {exp_mreq, exp_fd, exp_fd && d_err, exp_ed, exp_ed && d_err});
      if (exp_mreq) chk("rnd bus fields", {bus.m_write, bus.m_wstrb, bus.m_addr, bus.m_wdata}, m_exp);
      if (exp_fd)   chk("rnd f_rdata", bus.f_rdata, d_rdata);
      if (exp_ed)   chk("rnd e_rdata", bus.e_rdata, d_rdata);
      if ((t >= bf) && (t <= bt)) begin
        if (fl && !own_e) flush_seen = 1'b1;
        if (t == bt) begin
          done_t = t + 1;
          d_disc = flush_seen;
        end
      end else begin
        bit fv, ge, gf;
        fv = fr && !fl;
        ge = 1'b0;
        gf = 1'b0;
        if (er && fv) begin
          if (starve < STARVE_LIMIT) begin ge = 1'b1; starve++; end
          else begin gf = 1'b1; starve = 0; end
        end else if (er) ge = 1'b1;
        else if (fv) begin gf = 1'b1; starve = 0; end
        if (ge || gf) begin
          int          d, len;
          logic [31:0] r;
          d     = md.pop_front();
          r     = mrd.pop_front();
          len   = (d + 1 <= TIMEOUT_CYCLES) ? d + 1 : TIMEOUT_CYCLES;
          d_err = (d + 1 > TIMEOUT_CYCLES);
          bf = t + 1; bt = t + len;
          own_e = ge; d_e = ge; flush_seen = 1'b0;
          if (ge) begin
            m_exp   = {ew, ew ? es : 4'h0, ea, ewd};
            d_rdata = (d_err || ew) ? 32'h0 : r;
          end else begin
            m_exp   = {1'b0, 4'h0, fa, 32'h0};
            d_rdata = d_err ? 32'h0 : r;
          end
        end
      end
      tick();
    end
    bus.f_req = 1'b0;
    bus.e_req = 1'b0;
    flush     = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[7];
    vec_t        v;
    logic [15:0] seq;
    int          got;

    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.e_req = 1'b0; bus.e_write = 1'b0; bus.e_addr = '0; bus.e_wdata = '0; bus.e_wstrb = '0;
    bus.m_done = 1'b0; bus.m_rdata = '0;

    //           is_e  wr    addr          wdata         wstrb  dly   rdata         exp_rdata     err   lat
    vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,  0,    32'h0050_0093, 32'h0050_0093, 1'b0, 2};
    vt[1] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'h0,  1000, 32'h0,         32'h0,         1'b1, 9};
    vt[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'h0,  7,    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 9};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0,  8,    32'h1234_0000, 32'h0,         1'b1, 9};
    vt[4] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 2,    32'h1234_5678, 32'h0,         1'b0, 4};
    vt[5] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,        4'h0,  3,    32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 5};
    vt[6] = '{1'b1, 1'b1, 32'h0000_2008, 32'h0000_BEEF, 4'h3, 0,    32'h7777_7777, 32'h0,         1'b0, 2};

    #3 nreset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_single(vt[i], $sformatf("vec%0d", i));

    // Contended start: store wins, fetch follows straight after e_done
    sq_delay.push_back(1); sq_data.push_back(32'h1111_2222);
    sq_delay.push_back(0); sq_data.push_back(32'h0000_0013);
    bus.f_req = 1'b1; bus.f_addr = 32'h200;
    bus.e_req = 1'b1; bus.e_write = 1'b1; bus.e_addr = 32'h2000;
    bus.e_wdata = 32'hDEAD_BEEF; bus.e_wstrb = 4'hF;
    tick();
    bus.e_req = 1'b0;
    @(negedge clock);
    chk("both: e grant", {bus.m_req, bus.m_write, bus.m_wstrb, bus.m_addr, bus.m_wdata},
        {1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF});
    tick(); @(negedge clock);
    tick(); @(negedge clock);
    chk("both: e_done", {bus.e_done, bus.e_error, bus.f_done, bus.m_req, bus.e_rdata},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    bus.f_req = 1'b0;
    @(negedge clock);
    chk("both: f grant", {bus.m_req, bus.m_write, bus.m_wstrb, bus.m_addr, bus.m_wdata},
        {1'b1, 1'b0, 4'h0, 32'h200, 32'h0});
    tick(); @(negedge clock);
    chk("both: f_done", {bus.f_done, bus.f_error, bus.e_done, bus.f_rdata},
        {1'b1, 1'b0, 1'b0, 32'h13});
    repeat (2) tick();

    // Starvation guard: E,E,E,E,F,E,E,E,E,F
    for (int i = 0; i < 10; i++) begin sq_delay.push_back(0); sq_data.push_back(32'h100 + i); end
    collect_grants(10, seq, got);
    chk("starve grant count", got, 10);
    chk("starve sequence", seq[9:0], 10'b10_0001_0000);
    repeat (3) tick();

    flush_case(1'b0, 3, 1, 8'b0000_1111, 8'b0000_0000, "flush mid fetch");
    v = '{1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3};
    run_single(v, "fetch after flush");
    flush_case(1'b0, 2, 2, 8'b0000_0111, 8'b0000_0000, "flush in done cycle");
    flush_case(1'b1, 1, 0, 8'b0000_0011, 8'b0000_0100, "flush during exec");

    // Flush while idle hides that cycle's fetch request
    bus.f_req = 1'b1; bus.f_addr = 32'h600; flush = 1'b1;
    tick();
    bus.f_req = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush masks idle fetch", bus.m_req, 1'b0);
    repeat (2) tick();

    // Reset during BUSY_E with starve counter at 3
    sq_delay.push_back(0);    sq_data.push_back(32'h1);
    sq_delay.push_back(0);    sq_data.push_back(32'h2);
    sq_delay.push_back(1000); sq_data.push_back(32'h3);
    collect_grants(3, seq, got);
    chk("pre-reset grants", {got[7:0], seq[2:0]}, {8'd3, 3'b000});
    #2 nreset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin sq_delay.push_back(0); sq_data.push_back(32'h200 + i); end
    collect_grants(5, seq, got);
    chk("post-reset starve", {got[7:0], seq[4:0]}, {8'd5, 5'b10000});
    repeat (2) tick();
    v = '{1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'h0, 0, 32'h0000_0AA5, 32'h0000_0AA5, 1'b0, 2};
    run_single(v, "fetch after reset");

    random_test(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
